// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller: FSM state codes,
// the sequential pcsource code, the hardwired-zero register and a decode helper.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    // One-hot decode of a register address into a 32-bit register map.
    function automatic logic [31:0] reg_onehot(input logic [4:0] addr);
        return 32'd1 << addr;
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register pending-writer counters for the 5-stage pipe.
// Exposes the registered busy map plus same-cycle views that already account
// for a WB release happening this cycle: pend_map (still >=1 writer after the
// release) and full_map (still at INFLIGHT_MAX writers after the release).
module pipe_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int INFLIGHT_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc_en,
    input  logic [4:0]  alloc_wa,
    input  logic        rel_en,
    input  logic [4:0]  rel_wa,
    output logic [31:0] busy_map,
    output logic [31:0] pend_map,
    output logic [31:0] full_map
);

    localparam int CW = $clog2(INFLIGHT_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(INFLIGHT_MAX);

    logic [CW-1:0] cnt [32];
    logic [CW-1:0] eff [32];
    logic [31:0]   alloc_vec;
    logic [31:0]   rel_vec;

    // Decode allocate/release requests; register 0 is never allocated.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alloc_vec = '0;
        rel_vec   = '0;
        if (alloc_en && (alloc_wa != REG_ZERO)) alloc_vec = reg_onehot(alloc_wa);
        if (rel_en)                             rel_vec   = reg_onehot(rel_wa);
    end

    // Count pending writers: +1 on allocate, -1 on release, unchanged on both, no underflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the counter array is reset explicitly because reset discards every in-flight write.
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                // NOTE: sequential state uses non-blocking assignments so all counters update together.
                if (alloc_vec[r] && !rel_vec[r]) begin
                    cnt[r] <= cnt[r] + CW'(1);
                end else if (!alloc_vec[r] && rel_vec[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
        end
    end

    // Derive registered and release-bypassed occupancy maps.
    always_comb begin
        busy_map = '0;
        pend_map = '0;
        full_map = '0;
        for (int r = 0; r < 32; r++) begin
            eff[r]      = cnt[r] - CW'(rel_vec[r] && (cnt[r] != '0));
            busy_map[r] = (cnt[r] != '0);
            pend_map[r] = (eff[r] != '0);
            full_map[r] = (eff[r] == CNT_MAX);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock/flush sequencer beside the ID stage of the 5-stage pipe.
// Stalls ID on RAW hazards against in-flight writers (with same-cycle WB
// bypass), stalls a writer whose destination is saturated, and squashes
// FLUSH_CYC IF slots after a taken control transfer.
// Optional build macro: PIPE_PERF_CNT_EN adds stall_cnt/flush_cnt counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int INFLIGHT_MAX = 3,
    parameter int FLUSH_CYC    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_ra1,
    input  logic [4:0]  id_ra2,
    input  logic        id_use1,
    input  logic        id_use2,
    input  logic [4:0]  id_wa,
    input  logic        id_wrf,
    input  logic [1:0]  id_pcsource,
    input  logic        wb_rel,
    input  logic [4:0]  wb_wa,
    output logic        pc_hold,
    output logic        ex_bubble,
    output logic        if_flush,
    output logic        issue,
    output logic [31:0] busy_map
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYC - 1);

    logic [1:0]  state;
    logic [1:0]  fcnt;
    logic [31:0] pend_map;
    logic [31:0] full_map;
    logic        in_flush;
    logic        raw1;
    logic        raw2;
    logic        sat;
    logic        haz;
    logic        taken;

    pipe_scoreboard #(
        .INFLIGHT_MAX (INFLIGHT_MAX)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .alloc_en (issue & id_wrf),
        .alloc_wa (id_wa),
        .rel_en   (wb_rel),
        .rel_wa   (wb_wa),
        .busy_map (busy_map),
        .pend_map (pend_map),
        .full_map (full_map)
    );

    // Hazard detection; the slot in ID during FLUSH is being squashed, so it never stalls.
    assign in_flush  = (state == ST_FLUSH);
    assign raw1      = id_use1 & (id_ra1 != REG_ZERO) & pend_map[id_ra1];
    assign raw2      = id_use2 & (id_ra2 != REG_ZERO) & pend_map[id_ra2];
    assign sat       = id_wrf & (id_wa != REG_ZERO) & full_map[id_wa];
    assign haz       = id_valid & ~in_flush & (raw1 | raw2 | sat);
    assign taken     = (id_pcsource != PCSRC_SEQ);

    assign issue     = id_valid & ~haz & ~in_flush;
    assign pc_hold   = haz;
    assign ex_bubble = haz;
    assign if_flush  = in_flush;

    // Sequence RUN/STALL/FLUSH; RUN and STALL share exits because a stall releases by issuing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
            fcnt  <= '0;
        end else begin
            case (state)
                ST_RUN, ST_STALL: begin
                    if (haz) begin
                        state <= ST_STALL;
                    end else if (issue && taken) begin
                        state <= ST_FLUSH;
                        fcnt  <= FCNT_INIT;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (fcnt == 2'd0) state <= ST_RUN;
                    else              fcnt  <= fcnt - 2'd1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Count stalled and flushed cycles; both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (haz)      stall_cnt <= stall_cnt + 32'd1;
            if (in_flush) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a per-register pending-writer model
// checks every cycle, directed vectors pin hand-computed values.
// A second instance with FLUSH_CYC=2 shares the stimulus.
// Honours PIPE_PERF_CNT_EN for the performance counter ports.
module tb_pipe_hazard_ctrl;

    localparam int MAXW  = 3;
    localparam int FLUSH = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use1, id_use2, id_wrf, wb_rel;
    logic [4:0]  id_ra1, id_ra2, id_wa, wb_wa;
    logic [1:0]  id_pcsource;
    logic        pc_hold, ex_bubble, if_flush, issue;
    logic        pc_hold2, ex_bubble2, if_flush2, issue2;
    logic [31:0] busy_map, busy_map2;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.INFLIGHT_MAX(MAXW), .FLUSH_CYC(FLUSH)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
        .id_use1(id_use1), .id_use2(id_use2), .id_wa(id_wa), .id_wrf(id_wrf),
        .id_pcsource(id_pcsource), .wb_rel(wb_rel), .wb_wa(wb_wa),
        .pc_hold(pc_hold), .ex_bubble(ex_bubble), .if_flush(if_flush), .issue(issue),
        .busy_map(busy_map)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    pipe_hazard_ctrl #(.INFLIGHT_MAX(MAXW), .FLUSH_CYC(2)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
        .id_use1(id_use1), .id_use2(id_use2), .id_wa(id_wa), .id_wrf(id_wrf),
        .id_pcsource(id_pcsource), .wb_rel(wb_rel), .wb_wa(wb_wa),
        .pc_hold(pc_hold2), .ex_bubble(ex_bubble2), .if_flush(if_flush2), .issue(issue2),
        .busy_map(busy_map2)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cnt [32];
    int          m_flush_left;
    int          m_stall_cnt, m_flush_cnt;
    int          eff [32];
    logic        e_haz, e_issue, e_flush, a_hit, r_hit;
    logic [31:0] e_busy;

    always @(negedge clk) begin
        if (!rst) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_flush_left = 0;
            m_stall_cnt  = 0;
            m_flush_cnt  = 0;
            check("rst_hold",  {31'd0, pc_hold},   32'd0);
            check("rst_bubble",{31'd0, ex_bubble}, 32'd0);
            check("rst_flush", {31'd0, if_flush},  32'd0);
            check("rst_issue", {31'd0, issue},     32'd0);
            check("rst_busy",  busy_map,           32'd0);
            check("rst_busy2", busy_map2,          32'd0);
`ifdef PIPE_PERF_CNT_EN
            check("rst_stall_cnt", stall_cnt, 32'd0);
            check("rst_flush_cnt", flush_cnt, 32'd0);
`endif
        end else begin
            for (int r = 0; r < 32; r++)
                eff[r] = m_cnt[r] - ((wb_rel && int'(wb_wa) == r && m_cnt[r] > 0) ? 1 : 0);
            e_flush = (m_flush_left > 0);
            e_haz   = !e_flush && id_valid &&
                      ((id_use1 && id_ra1 != 5'd0 && eff[id_ra1] > 0) ||
                       (id_use2 && id_ra2 != 5'd0 && eff[id_ra2] > 0) ||
                       (id_wrf  && id_wa  != 5'd0 && eff[id_wa] == MAXW));
            e_issue = id_valid && !e_haz && !e_flush;
            for (int r = 0; r < 32; r++) e_busy[r] = (m_cnt[r] > 0);

            check("pc_hold",   {31'd0, pc_hold},    {31'd0, e_haz});
            check("ex_bubble", {31'd0, ex_bubble},  {31'd0, e_haz});
            check("if_flush",  {31'd0, if_flush},   {31'd0, e_flush});
            check("issue",     {31'd0, issue},      {31'd0, e_issue});
            check("busy_map",  busy_map,            e_busy);
            check("pc_hold2",  {31'd0, pc_hold2},   {31'd0, e_haz});
            check("ex_bubble2",{31'd0, ex_bubble2}, {31'd0, e_haz});
            check("busy_map2", busy_map2,           e_busy);
`ifdef PIPE_PERF_CNT_EN
            check("stall_cnt", stall_cnt, m_stall_cnt);
            check("flush_cnt", flush_cnt, m_flush_cnt);
            m_stall_cnt += e_haz ? 1 : 0;
            m_flush_cnt += e_flush ? 1 : 0;
`endif
            // advance the model to the state after the coming clock edge
            for (int r = 0; r < 32; r++) begin
                a_hit = e_issue && id_wrf && int'(id_wa) == r && r != 0;
                r_hit = wb_rel && int'(wb_wa) == r;
                if (a_hit && !r_hit)                    m_cnt[r]++;
                else if (!a_hit && r_hit && m_cnt[r] > 0) m_cnt[r]--;
            end
            if (e_flush)                              m_flush_left--;
            else if (e_issue && id_pcsource != 2'b00) m_flush_left = FLUSH;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs;
        id_valid = 0; id_use1 = 0; id_use2 = 0; id_wrf = 0; wb_rel = 0;
        id_ra1 = 0; id_ra2 = 0; id_wa = 0; wb_wa = 0; id_pcsource = 2'b00;
    endtask

    task automatic to_neg;
        @(negedge clk); #1;
    endtask

    task automatic to_next;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic writer(input logic [4:0] wa);
        id_valid = 1; id_wrf = 1; id_wa = wa;
    endtask

    task automatic release_reg(input logic [4:0] wa);
        wb_rel = 1; wb_wa = wa;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        idle_inputs();
        @(posedge clk); #1;

        // 1. reset held two cycles, then released
        for (int i = 0; i < 2; i++) begin
            to_neg(); check("t1_rst_issue", {31'd0, issue}, 32'd0); to_next();
        end
        rst = 1;
        to_neg(); check("t1_idle_issue", {31'd0, issue}, 32'd0);
        check("t1_idle_busy", busy_map, 32'd0); to_next();

        // 2. RAW stall on $8, released by WB bypass
        writer(5'd8);
        to_neg(); check("t2_wr_issue", {31'd0, issue}, 32'd1); to_next();
        for (int i = 0; i < 2; i++) begin
            id_valid = 1; id_use1 = 1; id_ra1 = 5'd8;
            to_neg(); check("t2_hold", {31'd0, pc_hold}, 32'd1);
            check("t2_noissue", {31'd0, issue}, 32'd0);
            check("t2_busy8", busy_map, 32'h0000_0100); to_next();
        end
        id_valid = 1; id_use1 = 1; id_ra1 = 5'd8; release_reg(5'd8);
        to_neg(); check("t2_rel_hold", {31'd0, pc_hold}, 32'd0);
        check("t2_rel_issue", {31'd0, issue}, 32'd1); to_next();
        to_neg(); check("t2_busy_clear", busy_map, 32'd0); to_next();

        // 3. $0 is never busy
        writer(5'd0);
        to_neg(); check("t3_wr0_issue", {31'd0, issue}, 32'd1); to_next();
        id_valid = 1; id_use1 = 1; id_use2 = 1;
        to_neg(); check("t3_rd0_issue", {31'd0, issue}, 32'd1);
        check("t3_busy", busy_map, 32'd0); to_next();

        // 4. simultaneous allocate/release on $5
        writer(5'd5); to_neg(); to_next();
        writer(5'd5); release_reg(5'd5);
        to_neg(); check("t4_issue", {31'd0, issue}, 32'd1); to_next();
        to_neg(); check("t4_busy5", busy_map, 32'h0000_0020); to_next();
        release_reg(5'd5); to_neg(); to_next();
        to_neg(); check("t4_busy_clear", busy_map, 32'd0); to_next();

        // 5. taken branch: FLUSH_CYC=1 and FLUSH_CYC=2 instances
        id_valid = 1; id_pcsource = 2'b01;
        to_neg(); check("t5_br_issue", {31'd0, issue}, 32'd1);
        check("t5_br_noflush", {31'd0, if_flush}, 32'd0); to_next();
        id_valid = 1;
        to_neg(); check("t5_flush1", {31'd0, if_flush}, 32'd1);
        check("t5_flush_noissue", {31'd0, issue}, 32'd0);
        check("t5_flush_nohold", {31'd0, pc_hold}, 32'd0);
        check("t5_d2_flush1", {31'd0, if_flush2}, 32'd1);
        check("t5_d2_noissue", {31'd0, issue2}, 32'd0); to_next();
        to_neg(); check("t5_run", {31'd0, if_flush}, 32'd0);
        check("t5_d2_flush2", {31'd0, if_flush2}, 32'd1); to_next();
        to_neg(); check("t5_d2_run", {31'd0, if_flush2}, 32'd0);
`ifdef PIPE_PERF_CNT_EN
        check("t5_flush_cnt", flush_cnt, 32'd1);
`endif
        to_next();

        // 6. saturation: three writers to $3, fourth stalls until a release
        for (int i = 0; i < 3; i++) begin
            writer(5'd3); to_neg(); check("t6_wr_issue", {31'd0, issue}, 32'd1); to_next();
        end
        for (int i = 0; i < 2; i++) begin
            writer(5'd3); to_neg(); check("t6_sat_hold", {31'd0, pc_hold}, 32'd1);
            check("t6_sat_noissue", {31'd0, issue}, 32'd0); to_next();
        end
        writer(5'd3); release_reg(5'd3);
        to_neg(); check("t6_sat_issue", {31'd0, issue}, 32'd1); to_next();
        release_reg(5'd3);
        to_neg(); check("t6_busy3", busy_map, 32'h0000_0008);
`ifdef PIPE_PERF_CNT_EN
        check("t6_stall_cnt", stall_cnt, 32'd4);
`endif
        to_next();
        release_reg(5'd3); to_neg(); to_next();
        release_reg(5'd3); to_neg(); to_next();
        to_neg(); check("t6_busy_clear", busy_map, 32'd0); to_next();

        // release of an empty register leaves it empty
        release_reg(5'd9); to_neg(); to_next();
        to_neg(); check("t7_no_underflow", busy_map, 32'd0); to_next();

        // rt-only hazard and unused-operand immunity
        writer(5'd12); to_neg(); to_next();
        id_valid = 1; id_ra1 = 5'd12; id_use2 = 1; id_ra2 = 5'd12;
        to_neg(); check("t8_rt_hold", {31'd0, pc_hold}, 32'd1); to_next();
        id_valid = 1; id_ra1 = 5'd12; id_ra2 = 5'd12;
        to_neg(); check("t8_unused_issue", {31'd0, issue}, 32'd1); to_next();

        // async reset mid-stall
        id_valid = 1; id_use2 = 1; id_ra2 = 5'd12;
        to_neg(); check("t9_stall", {31'd0, pc_hold}, 32'd1); to_next();
        rst = 0;
        to_neg(); check("t9_rst_hold", {31'd0, pc_hold}, 32'd0);
        check("t9_rst_busy", busy_map, 32'd0); to_next();
        rst = 1;
        to_neg(); check("t9_busy_after", busy_map, 32'd0); to_next();

        // async reset mid-flush
        id_valid = 1; id_pcsource = 2'b10; to_neg(); to_next();
        rst = 0;
        to_neg(); check("t10_rst_flush", {31'd0, if_flush}, 32'd0);
        check("t10_rst_flush2", {31'd0, if_flush2}, 32'd0); to_next();
        rst = 1;
        to_neg(); check("t10_run", {31'd0, if_flush}, 32'd0); to_next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
